// File: rtl/fetch_mem_responder_pkg.sv
// Shared constants and response type for the fetch_engine <-> memory responder interface.
// The response error flag only reaches the pins when FETCH_MEM_RSP_ERR_EN is defined.
package fetch_mem_responder_pkg;

    localparam int FETCH_ADDR_WIDTH = 16;
    localparam int FETCH_DATA_WIDTH = 32;

    typedef struct packed {
        logic [FETCH_DATA_WIDTH-1:0] data;
        logic                        err;
    } rsp_t;

endpackage

// File: rtl/fetch_mem_responder_rsp_fifo.sv
// First-word fall-through response buffer; head entry is visible while the FIFO is non-empty.
// The output reads zero when empty, so a reset also clears the visible response data.
module fetch_mem_responder_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_mem_responder.sv
// In-order word-read responder: preloadable SRAM, one-cycle registered read, credit-limited FWFT response buffer.
// Define FETCH_MEM_RSP_ERR_EN to flag out-of-range addresses via m_rsp_err instead of aliasing them.
module fetch_mem_responder
    import fetch_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = FETCH_ADDR_WIDTH,
    parameter int DATA_WIDTH     = FETCH_DATA_WIDTH,
    parameter int DEPTH          = 1024,
    parameter int RSP_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m_req_vld,
    output logic                  m_req_rdy,
    input  logic [ADDR_WIDTH-1:0] m_req_addr,
    output logic                  m_rsp_vld,
    input  logic                  m_rsp_rdy,
    output logic [DATA_WIDTH-1:0] m_rsp_data,
`ifdef FETCH_MEM_RSP_ERR_EN
    output logic                  m_rsp_err,
`endif
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW    = $clog2(RSP_FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(RSP_FIFO_DEPTH);
`ifdef FETCH_MEM_RSP_ERR_EN
    localparam int RSP_W = DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LO_MASK = ADDR_WIDTH'(DEPTH - 1);
`else
    localparam int RSP_W = DATA_WIDTH;
`endif

    logic [DATA_WIDTH-1:0] sram [DEPTH];
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;
    logic                  accept;
    logic                  req_oob;
    logic                  wr_ok;
    logic                  bypass;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [RSP_W-1:0]      fifo_in;
    logic [RSP_W-1:0]      fifo_out;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW:0]           outstanding;

    assign rd_idx = m_req_addr[IDX_W-1:0];
    assign wr_idx = wr_addr[IDX_W-1:0];

`ifdef FETCH_MEM_RSP_ERR_EN
    assign req_oob = |(m_req_addr & ~LO_MASK);
    assign wr_ok   = ~|(wr_addr & ~LO_MASK);
`else
    logic unused_addr_bits;
    assign req_oob          = 1'b0;
    assign wr_ok            = 1'b1;
    assign unused_addr_bits = ^{m_req_addr, wr_addr};
`endif

    // Credits count both the read in the pipeline and buffered responses, so a push never finds the FIFO full.
    assign outstanding = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
    assign m_req_rdy   = !rst && !fifo_full && (outstanding < CREDITS);
    assign accept      = m_req_vld && m_req_rdy;
    assign bypass      = wr_en && wr_ok && (wr_idx == rd_idx);
    assign busy        = inflight || !fifo_empty;
    assign m_rsp_vld   = !fifo_empty;

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            sram[wr_idx] <= wr_data;
        end
    end

    // A same-cycle preload to the requested word wins over the stale array contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
        end
        if (accept) begin
            if (req_oob) begin
                rd_data <= '0;
            end else if (bypass) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= sram[rd_idx];
            end
        end
    end

`ifdef FETCH_MEM_RSP_ERR_EN
    logic rd_err;

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_err <= req_oob;
        end
    end

    assign fifo_in               = {rd_err, rd_data};
    assign {m_rsp_err, m_rsp_data} = fifo_out;
`else
    assign fifo_in    = rd_data;
    assign m_rsp_data = fifo_out;
`endif

    fetch_mem_responder_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_in),
        .pop       (m_rsp_rdy),
        .pop_data  (fifo_out),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Directed self-checking bench for fetch_mem_responder; expectations follow FETCH_MEM_RSP_ERR_EN when defined.
module tb_fetch_mem_responder;

    logic        clk;
    logic        rst;
    logic        m_req_vld;
    logic        m_req_rdy;
    logic [15:0] m_req_addr;
    logic        m_rsp_vld;
    logic        m_rsp_rdy;
    logic [31:0] m_rsp_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        rsp_err_obs;
    logic [32:0] rsp_obs;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_mem [16];

    fetch_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .m_req_vld  (m_req_vld),
        .m_req_rdy  (m_req_rdy),
        .m_req_addr (m_req_addr),
        .m_rsp_vld  (m_rsp_vld),
        .m_rsp_rdy  (m_rsp_rdy),
        .m_rsp_data (m_rsp_data),
`ifdef FETCH_MEM_RSP_ERR_EN
        .m_rsp_err  (rsp_err_obs),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

`ifndef FETCH_MEM_RSP_ERR_EN
    assign rsp_err_obs = 1'b0;
`endif
    assign rsp_obs = {rsp_err_obs, m_rsp_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic vld, input logic [15:0] addr, input logic rsp_rdy);
        m_req_vld  = vld;
        m_req_addr = addr;
        m_rsp_rdy  = rsp_rdy;
    endtask

    task automatic preloadWord(input logic [15:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int accepted;
        int sent;
        int got;
        bit pend;
        bit held_v;
        logic [32:0] held;
        logic [32:0] exp_q [$];
        logic [32:0] expv;
        logic [15:0] a;

        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        applyStimulus(1'b0, 16'h0, 1'b1);
        step();
        step();
        checkOutput("rst_req_rdy", 64'(m_req_rdy), 64'd0);
        checkOutput("rst_rsp_vld", 64'(m_rsp_vld), 64'd0);
        checkOutput("rst_rsp", 64'(rsp_obs), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_req_rdy", 64'(m_req_rdy), 64'd1);

        // Streaming reads of freshly preloaded words.
        for (int i = 0; i < 8; i++) begin
            model_mem[i] = 32'hA000_0000 + 32'(i);
            preloadWord(16'(i), model_mem[i]);
        end
        applyStimulus(1'b1, 16'd0, 1'b1);
        step();
        checkOutput("t1_latency_vld0", 64'(m_rsp_vld), 64'd0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        applyStimulus(1'b1, 16'd1, 1'b1);
        step();
        checkOutput("t1_first_vld", 64'(m_rsp_vld), 64'd1);
        checkOutput("t1_rsp0", 64'(rsp_obs), 64'({1'b0, model_mem[0]}));
        for (int i = 2; i < 8; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b1);
            checkOutput("t1_req_rdy", 64'(m_req_rdy), 64'd1);
            step();
            checkOutput("t1_rsp_vld", 64'(m_rsp_vld), 64'd1);
            checkOutput("t1_rsp", 64'(rsp_obs), 64'({1'b0, model_mem[i-1]}));
        end
        applyStimulus(1'b0, 16'd0, 1'b1);
        step();
        checkOutput("t1_rsp7", 64'(rsp_obs), 64'({1'b0, model_mem[7]}));
        step();
        checkOutput("t1_drain_vld", 64'(m_rsp_vld), 64'd0);
        checkOutput("t1_drain_busy", 64'(busy), 64'd0);

        // Backpressure fills the credit window.
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b1, 16'(accepted), 1'b0);
            #1;
            if (m_req_rdy) accepted++;
            step();
        end
        checkOutput("t2_accepted", 64'(accepted), 64'd4);
        checkOutput("t2_req_rdy_full", 64'(m_req_rdy), 64'd0);
        checkOutput("t2_head", 64'(rsp_obs), 64'({1'b0, model_mem[0]}));
        applyStimulus(1'b0, 16'd0, 1'b1);
        #1;
        checkOutput("t2_no_comb_path", 64'(m_req_rdy), 64'd0);
        step();
        checkOutput("t2_rdy_reopen", 64'(m_req_rdy), 64'd1);
        for (int i = 1; i < 4; i++) begin
            checkOutput("t2_rsp", 64'(rsp_obs), 64'({1'b0, model_mem[i]}));
            step();
        end
        checkOutput("t2_drained", 64'(m_rsp_vld), 64'd0);

        // Write-first collision.
        wr_en = 1'b1;
        wr_addr = 16'd5;
        wr_data = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 16'd5, 1'b1);
        step();
        wr_en = 1'b0;
        model_mem[5] = 32'hDEAD_BEEF;
        applyStimulus(1'b0, 16'd0, 1'b1);
        checkOutput("t3_vld0", 64'(m_rsp_vld), 64'd0);
        step();
        checkOutput("t3_bypass", 64'(rsp_obs), 64'({1'b0, 32'hDEAD_BEEF}));
        step();

        // Reset with buffered responses.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0);
            step();
        end
        applyStimulus(1'b0, 16'd0, 1'b0);
        step();
        checkOutput("t4_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        checkOutput("t4_rst_vld", 64'(m_rsp_vld), 64'd0);
        checkOutput("t4_rst_busy", 64'(busy), 64'd0);
        checkOutput("t4_rst_rdy", 64'(m_req_rdy), 64'd0);
        rst = 1'b0;
        applyStimulus(1'b1, 16'd2, 1'b1);
        #1;
        checkOutput("t4_rdy_after", 64'(m_req_rdy), 64'd1);
        step();
        applyStimulus(1'b0, 16'd0, 1'b1);
        step();
        checkOutput("t4_mem_kept", 64'(rsp_obs), 64'({1'b0, model_mem[2]}));
        step();

        // Addresses above the SRAM range.
        applyStimulus(1'b1, 16'h0405, 1'b1);
        step();
        applyStimulus(1'b0, 16'd0, 1'b1);
        step();
`ifdef FETCH_MEM_RSP_ERR_EN
        checkOutput("t5_oob_read", 64'(rsp_obs), 64'({1'b1, 32'h0}));
`else
        checkOutput("t5_alias_read", 64'(rsp_obs), 64'({1'b0, model_mem[5]}));
`endif
        step();
        preloadWord(16'h0407, 32'h1234_5678);
`ifndef FETCH_MEM_RSP_ERR_EN
        model_mem[7] = 32'h1234_5678;
`endif
        applyStimulus(1'b1, 16'd7, 1'b1);
        step();
        applyStimulus(1'b0, 16'd0, 1'b1);
        step();
        checkOutput("t5_oob_write", 64'(rsp_obs), 64'({1'b0, model_mem[7]}));
        step();

        // Random traffic against a scoreboard.
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'hC000_0000 + 32'(i * 3);
            preloadWord(16'(i), model_mem[i]);
        end
        sent = 0;
        got = 0;
        pend = 1'b0;
        held_v = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            if (!pend) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    a = 16'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) == 0) a = a | 16'h0400;
                    m_req_vld = 1'b1;
                    m_req_addr = a;
                    pend = 1'b1;
                end else begin
                    m_req_vld = 1'b0;
                end
            end
            m_rsp_rdy = ($urandom_range(0, 2) != 0);
            #1;
            if (held_v) checkOutput("t6_stable", 64'(rsp_obs), 64'(held));
            if (m_req_vld && m_req_rdy) begin
`ifdef FETCH_MEM_RSP_ERR_EN
                expv = (m_req_addr[15:10] != 0) ? {1'b1, 32'h0} : {1'b0, model_mem[m_req_addr[3:0]]};
`else
                expv = {1'b0, model_mem[m_req_addr[3:0]]};
`endif
                exp_q.push_back(expv);
                sent++;
                pend = 1'b0;
            end
            if (m_rsp_vld && m_rsp_rdy) begin
                if (exp_q.size() == 0) begin
                    checkOutput("t6_spurious", 64'd1, 64'd0);
                end else begin
                    expv = exp_q.pop_front();
                    checkOutput("t6_data", 64'(rsp_obs), 64'(expv));
                end
                got++;
            end
            held_v = m_rsp_vld && !m_rsp_rdy;
            held = rsp_obs;
            step();
        end
        checkOutput("t6_count", 64'(got), 64'd1000);
        applyStimulus(1'b0, 16'd0, 1'b1);
        step();
        checkOutput("t6_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
